// File: rtl/product_accumulator.sv
// Accumulates a programmed number of unsigned products into a saturating
// wide sum, handing the total off on a valid/ready result port.
module product_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic             xfer;
  logic [ACC_W:0]   sum_full;

  assign in_ready     = (state_q == ST_ACCUM);
  assign out_valid    = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;

  assign xfer     = in_valid && in_ready;
  // Extra top bit captures the carry-out that triggers saturation.
  assign sum_full = {1'b0, acc_q} + (ACC_W+1)'(in_product);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d     = state_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = len;
          acc_d       = '0;
          ovf_d       = 1'b0;
          state_d     = (len == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (xfer) begin
          if (sum_full[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_full[ACC_W-1:0];
          end
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a default-width instance and a
// 17-bit-accumulator instance share stimulus so saturation can be exercised.
module tb_product_accumulator;

  localparam int PROD_W = 16;
  localparam int LEN_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic [PROD_W-1:0] in_product;
  logic              out_ready;

  logic              w_in_ready, w_out_valid, w_out_overflow, w_busy;
  logic [23:0]       w_out_sum;
  logic              n_in_ready, n_out_valid, n_out_overflow, n_busy;
  logic [16:0]       n_out_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(PROD_W), .ACC_W(24), .LEN_W(LEN_W)) u_wide (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_product(in_product),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_sum(w_out_sum),
    .out_overflow(w_out_overflow), .busy(w_busy)
  );

  product_accumulator #(.PROD_W(PROD_W), .ACC_W(17), .LEN_W(LEN_W)) u_narrow (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_product(in_product),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_sum(n_out_sum),
    .out_overflow(n_out_overflow), .busy(n_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic v, input logic [PROD_W-1:0] p);
    in_valid   = v;
    in_product = p;
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_product = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_in_ready",  32'(w_in_ready), 0);
    check("rst_out_valid", 32'(w_out_valid), 0);
    check("rst_out_sum",   32'(w_out_sum), 0);
    check("rst_overflow",  32'(w_out_overflow), 0);
    check("rst_busy",      32'(w_busy), 0);

    // Basic run: 42+75+24, consumer always ready.
    out_ready = 1'b1;
    start = 1'b1; len = 5'd3; step();
    start = 1'b0;
    check("t1_in_ready_after_start", 32'(w_in_ready), 1);
    check("t1_busy", 32'(w_busy), 1);
    feed(1'b1, 16'd42);
    feed(1'b1, 16'd75);
    check("t1_not_done_early", 32'(w_out_valid), 0);
    feed(1'b1, 16'd24);
    in_valid = 1'b0;
    check("t1_out_valid", 32'(w_out_valid), 1);
    check("t1_in_ready_low", 32'(w_in_ready), 0);
    check("t1_sum", 32'(w_out_sum), 141);
    check("t1_ovf", 32'(w_out_overflow), 0);
    // Start on the handshake edge must be ignored.
    start = 1'b1; len = 5'd5; step();
    start = 1'b0;
    check("t1_idle_valid", 32'(w_out_valid), 0);
    check("t1_idle_busy", 32'(w_busy), 0);
    check("t1_handshake_start_ignored", 32'(w_in_ready), 0);

    // Gapped input with garbage on idle beats, consumer stalls 4 cycles.
    out_ready = 1'b0;
    start = 1'b1; len = 5'd3; step();
    start = 1'b0;
    feed(1'b1, 16'd42);
    feed(1'b0, 16'd999);
    feed(1'b0, 16'd999);
    feed(1'b1, 16'd75);
    feed(1'b0, 16'd999);
    check("t2_not_done_early", 32'(w_out_valid), 0);
    feed(1'b1, 16'd24);
    in_valid = 1'b1; in_product = 16'd100;
    for (int i = 0; i < 4; i++) begin
      check("t2_hold_valid", 32'(w_out_valid), 1);
      check("t2_hold_sum", 32'(w_out_sum), 141);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1; step();
    check("t2_idle_valid", 32'(w_out_valid), 0);
    check("t2_idle_sum_retained", 32'(w_out_sum), 141);

    // Zero-length request completes immediately with a cleared result.
    start = 1'b1; len = 5'd0; out_ready = 1'b0; step();
    start = 1'b0;
    check("t3_out_valid", 32'(w_out_valid), 1);
    check("t3_sum", 32'(w_out_sum), 0);
    check("t3_ovf", 32'(w_out_overflow), 0);
    check("t3_in_ready", 32'(w_in_ready), 0);
    out_ready = 1'b1; step();
    check("t3_idle", 32'(w_busy), 0);

    // Saturation: 3 x 65535 exceeds 17 bits but fits in 24.
    start = 1'b1; len = 5'd3; step();
    start = 1'b0;
    out_ready = 1'b0;
    feed(1'b1, 16'hFFFF);
    feed(1'b1, 16'hFFFF);
    check("t4_narrow_no_ovf_yet", 32'(n_out_overflow), 0);
    feed(1'b1, 16'hFFFF);
    in_valid = 1'b0;
    check("t4_narrow_valid", 32'(n_out_valid), 1);
    check("t4_narrow_sum", 32'(n_out_sum), 131071);
    check("t4_narrow_ovf", 32'(n_out_overflow), 1);
    check("t4_wide_sum", 32'(w_out_sum), 196605);
    check("t4_wide_ovf", 32'(w_out_overflow), 0);
    out_ready = 1'b1; step();
    check("t4_narrow_ovf_retained", 32'(n_out_overflow), 1);
    start = 1'b1; len = 5'd1; step();
    start = 1'b0;
    check("t4_ovf_cleared_on_start", 32'(n_out_overflow), 0);
    out_ready = 1'b0;
    feed(1'b1, 16'd5);
    in_valid = 1'b0;
    check("t4b_narrow_sum", 32'(n_out_sum), 5);
    check("t4b_narrow_ovf", 32'(n_out_overflow), 0);
    out_ready = 1'b1; step();

    // Start pulses in ACCUM and DONE carry a different len and are ignored.
    start = 1'b1; len = 5'd2; step();
    start = 1'b1; len = 5'd7;
    feed(1'b1, 16'd10);
    start = 1'b0;
    feed(1'b1, 16'd20);
    in_valid = 1'b0;
    check("t5_done_after_two", 32'(w_out_valid), 1);
    check("t5_sum", 32'(w_out_sum), 30);
    out_ready = 1'b0; start = 1'b1; len = 5'd4; step();
    start = 1'b0;
    check("t5_still_done", 32'(w_out_valid), 1);
    check("t5_sum_unchanged", 32'(w_out_sum), 30);
    out_ready = 1'b1; step();
    check("t5_idle", 32'(w_busy), 0);

    // Reset mid-accumulation, then a fresh run.
    start = 1'b1; len = 5'd4; step();
    start = 1'b0;
    feed(1'b1, 16'd1);
    feed(1'b1, 16'd2);
    in_valid = 1'b0;
    rst = 1'b1; step();
    rst = 1'b0;
    check("t6_rst_busy", 32'(w_busy), 0);
    check("t6_rst_in_ready", 32'(w_in_ready), 0);
    check("t6_rst_out_valid", 32'(w_out_valid), 0);
    check("t6_rst_sum", 32'(w_out_sum), 0);
    check("t6_rst_ovf", 32'(w_out_overflow), 0);
    start = 1'b1; len = 5'd2; step();
    start = 1'b0;
    feed(1'b1, 16'd6);
    feed(1'b1, 16'd7);
    in_valid = 1'b0;
    check("t6_valid", 32'(w_out_valid), 1);
    check("t6_sum", 32'(w_out_sum), 13);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the 8x8 Russian-peasant multiplier's 16-bit products. Sums a programmed number of products (dot-product style) into a wider accumulator and presents the total on a valid/ready output handshake. Input side uses valid/ready, so the feeding stage stalls while a result is pending. Saturating arithmetic with a sticky overflow flag.

## Interface
- PROD_W, 16, width of incoming product (matches multiplier `product`)
- ACC_W, 24, accumulator/result width; must be >= PROD_W
- LEN_W, 5, width of term-count input (max 2^LEN_W-1 terms)

- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a new accumulation; honoured only in IDLE
- len  in  LEN_W  number of products to sum; sampled when start is honoured
- in_valid  in  1  in_product is valid this cycle
- in_ready  out  1  block accepts in_product this cycle
- in_product  in  PROD_W  unsigned product, zero-extended to ACC_W
- out_valid  out  1  out_sum/out_overflow hold a finished result
- out_ready  in  1  consumer accepts the result
- out_sum  out  ACC_W  accumulated (saturated) sum
- out_overflow  out  1  sum saturated during this accumulation
- busy  out  1  high in ACCUM and DONE

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=0, out_valid=0, busy=0. On start: latch len into remaining counter, clear acc and overflow. len!=0 -> ACCUM; len==0 -> DONE with out_sum=0, out_overflow=0.
- ACCUM: in_ready=1. Transfer = in_valid & in_ready. Per transfer: acc <= acc + product; remaining <= remaining-1. When remaining==1 at transfer, go DONE.
- Saturation: if the ACC_W-bit add carries out, acc <= all-ones and overflow <= 1 (sticky until next start). Further adds once saturated keep all-ones.
- DONE: out_valid=1, in_ready=0; out_sum and out_overflow held stable until handshake. On out_valid & out_ready -> IDLE.
- start ignored (no latch, no effect) in ACCUM and DONE. in_valid ignored outside ACCUM (in_ready=0, nothing consumed).
- out_sum/out_overflow retain the last result in IDLE until the next honoured start clears them.
- Reset in any state: abandon operation, state=IDLE, all registers cleared.

## Timing
- Reset values: in_ready=0, out_valid=0, out_sum=0, out_overflow=0, busy=0.
- start honoured at edge N -> ACCUM, in_ready=1 from cycle N+1.
- Throughput one product per cycle; in_valid gaps stall without penalty.
- Last transfer at edge K -> out_valid=1 from cycle K+1 (one-cycle latency), in_ready=0 same cycle.
- len==0: start at edge N -> out_valid=1 from cycle N+1.
- Result handshake at edge M -> out_valid=0, busy=0 from M+1; earliest next honoured start is edge M+1 (start at edge M is ignored).
- out_ready held low: out_valid, out_sum, out_overflow stay constant indefinitely.

## Test plan
- len=3, products 42,75,24 on consecutive cycles, out_ready=1 -> out_valid one cycle after third transfer, out_sum=141, out_overflow=0, IDLE next cycle.
- Same as above with in_valid gapped (1,0,0,1,0,1) and out_ready low 4 cycles -> out_sum=141 held stable with out_valid=1 until out_ready rises; exactly 3 products consumed.
- len=0 start -> out_valid at next cycle, out_sum=0, in_ready never asserted.
- ACC_W=17, len=3, products 65535,65535,65535 -> out_sum=131071, out_overflow=1; following run len=1 product 5 -> out_sum=5, out_overflow=0.
- start pulsed during ACCUM and DONE with different len -> ignored; term count and result unchanged.
- rst asserted after 2 of 4 products accepted -> next cycle IDLE, all outputs 0; fresh len=2 run of 6,7 -> out_sum=13.
